uart_cfg: RTL and testbench

//   Parametrised full-duplex UART, successor to the fixed 8N1 uart block.

---
 rtl/uart_cfg.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : uart_cfg                                                    |
// | Description: Parametrised full-duplex UART. Configurable data width,     |
// |              stop bits and RX oversampling, start-bit glitch rejection,  |
// |              RX FIFO with per-word error flags and a sticky overrun.     |
// | Option     : define UART_PARITY_EN to add a parity bit (even, or odd    |
// |              when PARITY_ODD=1) in both directions.                      |
// | Ports      : clk, reset_n (sync, active-low)                            |
// |              serial_rxd / serial_txd      - serial pins, idle high       |
// |              txd, txd_strobe, txd_ready   - transmit word handshake      |
// |              rxd, rxd_valid, rxd_ack      - FIFO head (fall-through)     |
// |              rx_frame_err, rx_parity_err  - head word error flags        |
// |              rx_overrun, rx_count         - sticky drop flag, occupancy  |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module uart_cfg #(
    parameter int DATA_BITS     = 8,
    parameter int DIVISOR       = 40,
    parameter int OVERSAMPLE    = 4,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4,
    parameter int PARITY_ODD    = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           serial_rxd,
    output logic                           serial_txd,
    input  logic [DATA_BITS-1:0]           txd,
    input  logic                           txd_strobe,
    output logic                           txd_ready,
    output logic [DATA_BITS-1:0]           rxd,
    output logic                           rxd_valid,
    input  logic                           rxd_ack,
    output logic                           rx_frame_err,
    output logic                           rx_parity_err,
    output logic                           rx_overrun,
    output logic [$clog2(RX_FIFO_DEPTH):0] rx_count
);

`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TX_BITS  = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int TX_SH_W  = TX_BITS - 1;          // everything after the start bit
    localparam int ENTRY_W  = DATA_BITS + 1 + PAR_BITS;
    localparam int TICK_DIV = DIVISOR / OVERSAMPLE;
    localparam int TMR_W    = $clog2(DIVISOR);
    localparam int TXB_W    = $clog2(TX_BITS);
    localparam int TICK_W   = $clog2(TICK_DIV + 1);
    localparam int OS_W     = $clog2(OVERSAMPLE);
    localparam int RXB_W    = $clog2(DATA_BITS);
    localparam int PTR_W    = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(DIVISOR - 1);
    localparam logic [TXB_W-1:0]  TX_LAST   = TXB_W'(TX_BITS - 1);
    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(TICK_DIV - 1);
    localparam logic [OS_W-1:0]   OS_MAX    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [RXB_W-1:0]  DB_LAST   = RXB_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(RX_FIFO_DEPTH);

    if (DATA_BITS < 5 || DATA_BITS > 9 || (DIVISOR % OVERSAMPLE) != 0 ||
        !(OVERSAMPLE == 4 || OVERSAMPLE == 8 || OVERSAMPLE == 16) ||
        STOP_BITS < 1 || STOP_BITS > 2 || RX_FIFO_DEPTH < 2 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_cfg: illegal parameter combination");
    end

    // ------------------------------------------------------------------ TX
    logic               txd_q, tx_ready_q, tx_busy_q;
    logic [TX_SH_W-1:0] tx_shift_q, tx_load_d;
    logic [TMR_W-1:0]   tx_tmr_q;
    logic [TXB_W-1:0]   tx_bit_q;

    // Bits following the start bit: data LSB first, optional parity, stop bits.
    always_comb begin
        tx_load_d                  = '1;
        tx_load_d[DATA_BITS-1:0]   = txd;
`ifdef UART_PARITY_EN
        tx_load_d[DATA_BITS]       = (^txd) ^ (PARITY_ODD != 0);
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_tmr_q == TMR_MAX) begin
                tx_tmr_q <= '0;
                if (tx_bit_q == TX_LAST) begin
                    tx_busy_q  <= 1'b0;
                    tx_ready_q <= 1'b1;
                    txd_q      <= 1'b1;
                end else begin
                    tx_bit_q   <= tx_bit_q + 1'b1;
                    txd_q      <= tx_shift_q[0];
                    tx_shift_q <= {1'b1, tx_shift_q[TX_SH_W-1:1]};
                end
            end else begin
                tx_tmr_q <= tx_tmr_q + 1'b1;
            end
        end else if (tx_ready_q && txd_strobe) begin
            txd_q      <= 1'b0;             // start bit on the cycle after the strobe
            tx_shift_q <= tx_load_d;
            tx_busy_q  <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_ready_q <= 1'b1;             // first idle cycle after reset release
        end
    end

    assign serial_txd = txd_q;
    assign txd_ready  = tx_ready_q;

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_e;

    rx_state_e            rx_state_q;
    logic [1:0]           sync_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic                 tick_q;
    logic [OS_W-1:0]      rx_os_q;
    logic [RXB_W-1:0]     rx_bit_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_push_q;
    logic [ENTRY_W-1:0]   rx_entry_q;
    logic                 rx_bit;
`ifdef UART_PARITY_EN
    logic                 rx_par_err_q;
`endif

    assign rx_bit = sync_q[1];

    // Synchroniser and free-running sample tick; the tick is not aligned to frames.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], serial_rxd};
            if (tick_cnt_q == TICK_MAX) begin
                tick_cnt_q <= '0;
                tick_q     <= 1'b1;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
                tick_q     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rx_push_q  <= 1'b0;
            rx_entry_q <= '0;
`ifdef UART_PARITY_EN
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            rx_push_q <= 1'b0;
            if (tick_q) begin
                case (rx_state_q)
                    RX_IDLE: begin
                        if (!rx_bit) begin
                            rx_state_q <= RX_START;
                            rx_os_q    <= '0;
                        end
                    end
                    RX_START: begin
                        // Re-check half a bit later; a high line means a glitch.
                        if (rx_os_q == OS_HALF) begin
                            rx_os_q    <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rx_bit ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_os_q <= rx_os_q + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_os_q == OS_MAX) begin
                            rx_os_q   <= '0;
                            rx_data_q <= {rx_bit, rx_data_q[DATA_BITS-1:1]};
                            if (rx_bit_q == DB_LAST) begin
`ifdef UART_PARITY_EN
                                rx_state_q <= RX_PARITY;
`else
                                rx_state_q <= RX_STOP;
`endif
                            end else begin
                                rx_bit_q <= rx_bit_q + 1'b1;
                            end
                        end else begin
                            rx_os_q <= rx_os_q + 1'b1;
                        end
                    end
`ifdef UART_PARITY_EN
                    RX_PARITY: begin
                        if (rx_os_q == OS_MAX) begin
                            rx_os_q      <= '0;
                            rx_par_err_q <= rx_bit ^ (^rx_data_q) ^ (PARITY_ODD != 0);
                            rx_state_q   <= RX_STOP;
                        end else begin
                            rx_os_q <= rx_os_q + 1'b1;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (rx_os_q == OS_MAX) begin
                            rx_os_q   <= '0;
                            rx_push_q <= 1'b1;
`ifdef UART_PARITY_EN
                            rx_entry_q <= {rx_par_err_q, ~rx_bit, rx_data_q};
`else
                            rx_entry_q <= {~rx_bit, rx_data_q};
`endif
                            // A low stop bit may be a break: wait for idle before rearming.
                            rx_state_q <= rx_bit ? RX_IDLE : RX_WAIT_HIGH;
                        end else begin
                            rx_os_q <= rx_os_q + 1'b1;
                        end
                    end
                    RX_WAIT_HIGH: begin
                        if (rx_bit) begin
                            rx_state_q <= RX_IDLE;
                        end
                    end
                    default: rx_state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // --------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   rx_count_q;
    logic               overrun_q;
    logic               fifo_full, fifo_pop, fifo_wr;
    logic [ENTRY_W-1:0] head;

    assign fifo_full = (rx_count_q == FIFO_FULL);
    assign fifo_pop  = rxd_ack && (rx_count_q != '0);
    // When full, a same-cycle pop frees the slot the push lands in.
    assign fifo_wr   = rx_push_q && (!fifo_full || fifo_pop);

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_q] <= rx_entry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rx_count_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   rx_count_q <= rx_count_q + 1'b1;
                2'b01:   rx_count_q <= rx_count_q - 1'b1;
                default: rx_count_q <= rx_count_q;
            endcase
            if (rx_push_q && !fifo_wr) begin
                overrun_q <= 1'b1;
            end else if (fifo_pop) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign head         = fifo_mem[rd_ptr_q];
    assign rxd          = head[DATA_BITS-1:0];
    assign rx_frame_err = head[DATA_BITS];
`ifdef UART_PARITY_EN
    assign rx_parity_err = head[DATA_BITS+1];
`else
    assign rx_parity_err = 1'b0;
`endif
    assign rxd_valid    = (rx_count_q != '0);
    assign rx_count     = rx_count_q;
    assign rx_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cfg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_uart_cfg                                                 |
// | Description: Self-checking bench for uart_cfg (default parameters).      |
// |              RX words are predicted into a scoreboard as frames are      |
// |              driven and compared as they are popped from the FIFO.      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_cfg;
    localparam int DATA_BITS = 8;
    localparam int DIVISOR   = 40;
    localparam int PAR_ODD   = 0;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int TX_BITS = 1 + DATA_BITS + PAR_BITS + 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_rxd = 1'b1;
    logic       txd_strobe = 1'b0;
    logic       rxd_ack = 1'b0;
    logic [7:0] txd = 8'h00;
    logic       serial_txd, txd_ready, rxd_valid, rx_frame_err, rx_parity_err, rx_overrun;
    logic [7:0] rxd;
    logic [2:0] rx_count;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];   // {parity_err, frame_err, data}

    uart_cfg #(
        .DATA_BITS(8), .DIVISOR(40), .OVERSAMPLE(4), .STOP_BITS(1),
        .RX_FIFO_DEPTH(4), .PARITY_ODD(PAR_ODD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .serial_rxd(serial_rxd), .serial_txd(serial_txd),
        .txd(txd), .txd_strobe(txd_strobe), .txd_ready(txd_ready),
        .rxd(rxd), .rxd_valid(rxd_valid), .rxd_ack(rxd_ack),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [TX_BITS-1:0] tx_frame(input logic [7:0] d);
        logic [TX_BITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = (^d) ^ (PAR_ODD != 0);
`endif
        return f;
    endfunction

    task automatic drive_bit(input logic b);
        serial_rxd = b;
        repeat (DIVISOR) @(negedge clk);
    endtask

    // Drive one RX frame; bad_par inverts the parity bit, stop_low holds the line low first.
    task automatic send_rx(input logic [7:0] d, input int stop_low, input logic bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ (PAR_ODD != 0) ^ bad_par);
`else
        if (bad_par) serial_rxd = 1'b1;
`endif
        if (stop_low > 0) begin
            serial_rxd = 1'b0;
            repeat (stop_low) @(negedge clk);
        end
        drive_bit(1'b1);
    endtask

    task automatic sb_pop_compare(input string tag);
        logic [9:0] exp;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, rxd_valid=%b", tag, rxd_valid);
        end else begin
            exp = sb.pop_front();
            if (rxd_valid !== 1'b1 || rxd !== exp[7:0] || rx_frame_err !== exp[8] ||
                rx_parity_err !== exp[9]) begin
                errors++;
                $display("FAIL %s: valid=%b rxd=%h fe=%b pe=%b, expected valid=1 rxd=%h fe=%b pe=%b",
                         tag, rxd_valid, rxd, rx_frame_err, rx_parity_err, exp[7:0], exp[8], exp[9]);
            end
        end
        rxd_ack = 1'b1;
        @(negedge clk);
        rxd_ack = 1'b0;
    endtask

    task automatic wait_tx_ready(input int budget, input string tag);
        int n;
        n = 0;
        while (txd_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (txd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: txd_ready=%b after %0d cycles, expected 1", tag, txd_ready, budget);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (serial_txd !== 1'b1 || txd_ready !== 1'b0 || rxd_valid !== 1'b0 ||
            rx_count !== 3'd0 || rx_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: txd=%b ready=%b valid=%b count=%0d ovr=%b, expected 1 0 0 0 0",
                     serial_txd, txd_ready, rxd_valid, rx_count, rx_overrun);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: txd_ready=%b, expected 1", txd_ready);
        end
    endtask

    task automatic test_tx();
        logic [TX_BITS-1:0] f;
        int bi;
        f = tx_frame(8'hA5);
        wait_tx_ready(10, "tx_initial_ready");
        txd = 8'hA5;
        txd_strobe = 1'b1;
        @(negedge clk);
        txd_strobe = 1'b0;
        for (int k = 1; k <= TX_BITS * DIVISOR; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 100) begin txd = 8'h00; txd_strobe = 1'b1; end  // must be ignored
            if (k == 101) begin txd_strobe = 1'b0; end
            bi = (k - 1) / DIVISOR;
            if ((k - 1) % DIVISOR == 0 || (k - 1) % DIVISOR == DIVISOR - 1) begin
                checks++;
                if (serial_txd !== f[bi]) begin
                    errors++;
                    $display("FAIL tx_a5_bit%0d: cycle t0+%0d serial_txd=%b, expected %b",
                             bi, k, serial_txd, f[bi]);
                end
            end
        end
        checks++;
        if (txd_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_ready_early: txd_ready=%b in last stop cycle, expected 0", txd_ready);
        end
        @(negedge clk);
        checks++;
        if (txd_ready !== 1'b1 || serial_txd !== 1'b1) begin
            errors++;
            $display("FAIL tx_done: ready=%b txd=%b at t0+%0d, expected 1 1",
                     txd_ready, serial_txd, TX_BITS * DIVISOR + 1);
        end
        txd = 8'h3C;
        txd_strobe = 1'b1;
        @(negedge clk);
        txd_strobe = 1'b0;
        checks++;
        if (serial_txd !== 1'b0 || txd_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_back_to_back: txd=%b ready=%b, expected start bit 0 and ready 0",
                     serial_txd, txd_ready);
        end
        wait_tx_ready(TX_BITS * DIVISOR + 10, "tx_second_frame_done");
    endtask

    task automatic test_rx_basic();
        sb.push_back({2'b00, 8'h3C});
        send_rx(8'h3C, 0, 1'b0);
        sb.push_back({2'b00, 8'hFF});
        send_rx(8'hFF, 0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (rx_count !== 3'd2) begin
            errors++;
            $display("FAIL rx_basic_count: rx_count=%0d, expected 2", rx_count);
        end
        sb_pop_compare("rx_3c");
        sb_pop_compare("rx_ff");
        checks++;
        if (rxd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_basic_empty: rxd_valid=%b, expected 0", rxd_valid);
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back({2'b00, 8'(i)});
            send_rx(8'(i), 0, 1'b0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (rx_count !== 3'd4 || rx_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_full: count=%0d ovr=%b, expected 4 1", rx_count, rx_overrun);
        end
        sb_pop_compare("overrun_w1");
        checks++;
        if (rx_overrun !== 1'b0 || rx_count !== 3'd3) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b count=%0d, expected 0 3", rx_overrun, rx_count);
        end
        sb_pop_compare("overrun_w2");
        sb_pop_compare("overrun_w3");
        sb_pop_compare("overrun_w4");
        checks++;
        if (rxd_valid !== 1'b0 || rx_count !== 3'd0) begin
            errors++;
            $display("FAIL overrun_drained: valid=%b count=%0d, expected 0 0", rxd_valid, rx_count);
        end
    endtask

    task automatic test_frame_err();
        sb.push_back({2'b01, 8'h55});
        send_rx(8'h55, 200, 1'b0);
        repeat (400) @(negedge clk);
        checks++;
        if (rx_count !== 3'd1) begin
            errors++;
            $display("FAIL frame_err_count: rx_count=%0d after break, expected 1", rx_count);
        end
        sb_pop_compare("frame_err_55");
    endtask

    task automatic test_glitch();
        serial_rxd = 1'b0;
        repeat (10) @(negedge clk);
        serial_rxd = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if (rx_count !== 3'd0 || rxd_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject: count=%0d valid=%b, expected 0 0", rx_count, rxd_valid);
        end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        sb.push_back({2'b10, 8'h01});
        send_rx(8'h01, 0, 1'b1);
        repeat (4) @(negedge clk);
        sb_pop_compare("parity_err_01");
    endtask
`endif

    task automatic test_reset_midframe();
        send_rx(8'h42, 0, 1'b0);   // left in the FIFO to be cleared by reset
        repeat (4) @(negedge clk);
        checks++;
        if (rx_count !== 3'd1) begin
            errors++;
            $display("FAIL midframe_prefill: rx_count=%0d, expected 1", rx_count);
        end
        wait_tx_ready(10, "midframe_ready");
        txd = 8'hA5;
        txd_strobe = 1'b1;
        @(negedge clk);
        txd_strobe = 1'b0;
        repeat (99) @(negedge clk);  // cycle t0+100: data bit 1 of 0xA5 = 0
        checks++;
        if (serial_txd !== 1'b0 || txd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midframe_busy: txd=%b ready=%b, expected 0 0", serial_txd, txd_ready);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (serial_txd !== 1'b1 || txd_ready !== 1'b0 || rx_count !== 3'd0 ||
            rxd_valid !== 1'b0 || rx_overrun !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset: txd=%b ready=%b count=%0d valid=%b ovr=%b, expected 1 0 0 0 0",
                     serial_txd, txd_ready, rx_count, rxd_valid, rx_overrun);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (txd_ready !== 1'b1 || serial_txd !== 1'b1) begin
            errors++;
            $display("FAIL midframe_release: ready=%b txd=%b, expected 1 1", txd_ready, serial_txd);
        end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_rx_basic();
        test_overrun();
        test_frame_err();
        test_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run not complete at time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
